// File: rtl/ir_queue_decode.sv
// Instruction queue with registered MIPS decode stage.
// Fetched instructions (with PCs) are buffered in a DEPTH-entry FIFO; the head
// is decoded into an output register guarded by a valid/ready handshake.
// When the queue is empty an accepted instruction bypasses straight into the
// output register, giving one cycle from accept to out_valid.
module ir_queue_decode #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_ir,
  input  logic [PC_W-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [5:0]                 out_op,
  output logic [4:0]                 out_rs,
  output logic [4:0]                 out_rt,
  output logic [4:0]                 out_rd,
  output logic [4:0]                 out_shamt,
  output logic [5:0]                 out_funct,
  output logic [DATA_W-1:0]          out_imm,
  output logic                       out_is_rtype,
  output logic                       out_is_imm,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]     mem_ir [DEPTH];
  logic [PC_W-1:0] mem_pc [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            ready_en;

  logic            accept;
  logic            pop;
  logic            load_out;
  logic            from_queue;
  logic            bypass;
  logic            enq;
  logic [31:0]     src_ir;
  logic [PC_W-1:0] src_pc;
  logic [5:0]      src_op;
  logic [5:0]      src_funct;
  logic            dec_rtype;
  logic            dec_imm;
  logic            dec_zero_ext;
  logic [DATA_W-1:0] dec_ext;

  // Handshake qualifiers and selection of the output-register source.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    in_ready   = ready_en && (count < CW'(DEPTH)) && !flush;
    accept     = in_valid && in_ready;
    pop        = out_valid && out_ready;
    load_out   = !out_valid || pop;
    from_queue = load_out && (count != '0);
    bypass     = load_out && (count == '0) && accept;
    enq        = accept && !bypass;
    src_ir     = from_queue ? mem_ir[rd_ptr] : in_ir;
    src_pc     = from_queue ? mem_pc[rd_ptr] : in_pc;
  end

  // Decode of whichever word is about to enter the output register.
  always_comb begin
    src_op       = src_ir[31:26];
    src_funct    = src_ir[5:0];
    dec_rtype    = (src_op == 6'h00) &&
                   (src_funct inside {6'h20, 6'h21, 6'h24, 6'h25, 6'h00});
    dec_imm      = src_op inside {6'h08, 6'h09, 6'h0C, 6'h0D};
    dec_zero_ext = (src_op == 6'h0C) || (src_op == 6'h0D);
    dec_ext      = dec_zero_ext ? DATA_W'(src_ir[15:0])
                                : DATA_W'($signed(src_ir[15:0]));
  end

  // Queue storage write; no reset needed because occupancy lives in count.
  // NOTE: the storage array is deliberately left out of reset -- count and the
  // pointers decide which entries are meaningful, and a resettable array costs
  // a reset net on every bit.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_ir[wr_ptr] <= in_ir;
      mem_pc[wr_ptr] <= in_pc;
    end
  end

  // Pointers, occupancy and the registered decode stage; flush wins over all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      ready_en     <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_op       <= '0;
      out_rs       <= '0;
      out_rt       <= '0;
      out_rd       <= '0;
      out_shamt    <= '0;
      out_funct    <= '0;
      out_imm      <= '0;
      out_is_rtype <= 1'b0;
      out_is_imm   <= 1'b0;
      out_illegal  <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (flush) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        out_valid <= 1'b0;
      end else begin
        if (enq)        wr_ptr <= wr_ptr + 1'b1;
        if (from_queue) rd_ptr <= rd_ptr + 1'b1;
        case ({enq, from_queue})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
        if (load_out) begin
          out_valid <= from_queue || bypass;
          if (from_queue || bypass) begin
            out_pc       <= src_pc;
            out_op       <= src_op;
            out_rs       <= src_ir[25:21];
            out_rt       <= src_ir[20:16];
            out_rd       <= src_ir[15:11];
            out_shamt    <= src_ir[10:6];
            out_funct    <= src_funct;
            out_imm      <= dec_ext;
            out_is_rtype <= dec_rtype;
            out_is_imm   <= dec_imm;
            out_illegal  <= !(dec_rtype || dec_imm);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ir_queue_decode.sv
// Scoreboard bench for ir_queue_decode: the driver pushes expected decodes for
// every accepted instruction, an independent monitor compares the output stage.
module tb_ir_queue_decode;

  localparam int DATA_W = 32;
  localparam int PC_W   = 32;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_ir;
  logic [PC_W-1:0]   in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [5:0]        out_op;
  logic [4:0]        out_rs, out_rt, out_rd, out_shamt;
  logic [5:0]        out_funct;
  logic [DATA_W-1:0] out_imm;
  logic              out_is_rtype, out_is_imm, out_illegal;
  logic [$clog2(DEPTH):0] count;

  ir_queue_decode #(.DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ir(in_ir), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_op(out_op), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_shamt(out_shamt), .out_funct(out_funct), .out_imm(out_imm),
    .out_is_rtype(out_is_rtype), .out_is_imm(out_is_imm),
    .out_illegal(out_illegal), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [31:0] imm;
    logic        rtype, immf, illegal;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic        exp_ready;
  logic        ren_m;
  logic [31:0] pc_next = 32'h0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural decode: straight from the instruction-set rules.
  function automatic exp_t model(input logic [31:0] ir, input logic [31:0] pc);
    exp_t e;
    e.pc = pc; e.op = ir[31:26]; e.rs = ir[25:21]; e.rt = ir[20:16];
    e.rd = ir[15:11]; e.shamt = ir[10:6]; e.funct = ir[5:0];
    e.imm = ir[15] ? (32'hffff0000 | {16'h0, ir[15:0]}) : {16'h0, ir[15:0]};
    e.rtype = 0; e.immf = 0; e.illegal = 1;
    case (ir[31:26])
      6'd0: if (ir[5:0] == 6'd32 || ir[5:0] == 6'd33 || ir[5:0] == 6'd36 ||
                ir[5:0] == 6'd37 || ir[5:0] == 6'd0) begin
              e.rtype = 1; e.illegal = 0;
            end
      6'd8, 6'd9:   begin e.immf = 1; e.illegal = 0; end
      6'd12, 6'd13: begin e.immf = 1; e.illegal = 0; e.imm = {16'h0, ir[15:0]}; end
      default: ;
    endcase
    return e;
  endfunction

  // Model of the post-reset ready enable: one clock edge after reset release.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) ren_m <= 1'b0;
    else        ren_m <= 1'b1;

  // Monitor: occupancy/handshake checks and in-order comparison of the head.
  always @(negedge clk) begin
    exp_t got;
    int   n;
    #2;
    n = sb.size();
    check("out_valid", 128'(out_valid), 128'(n > 0));
    check("count", 128'(count), 128'(n > 0 ? n - 1 : 0));
    exp_ready = ren_m && !flush && (n <= DEPTH);
    check("in_ready", 128'(in_ready), 128'(exp_ready));
    if (out_valid && n > 0) begin
      got = {out_pc, out_op, out_rs, out_rt, out_rd, out_shamt, out_funct,
             out_imm, out_is_rtype, out_is_imm, out_illegal};
      check("decode", 128'(got), 128'(sb[0]));
      if (out_ready) void'(sb.pop_front());
    end
    if (flush) sb.delete();
  end

  // One cycle of stimulus; records an accept from the model's own ready.
  task automatic cyc(input logic v, input logic [31:0] ir, input logic rdy, input logic fl);
    @(negedge clk);
    in_valid = v; in_ir = ir; in_pc = pc_next; out_ready = rdy; flush = fl;
    #3;
    if (v && exp_ready) begin
      sb.push_back(model(ir, pc_next));
      pc_next += 32'd4;
    end
  endtask

  function automatic logic [31:0] rand_ir();
    logic [31:0] r;
    logic [5:0]  op, f;
    r = $urandom();
    case ($urandom_range(0, 5))
      0: op = 6'h00; 1: op = 6'h08; 2: op = 6'h09;
      3: op = 6'h0C; 4: op = 6'h0D; default: op = r[31:26];
    endcase
    case ($urandom_range(0, 3))
      0: f = 6'h20; 1: f = 6'h21; 2: f = 6'h00; default: f = r[5:0];
    endcase
    return {op, r[25:6], f};
  endfunction

  initial begin
    rst_n = 0; flush = 0; in_valid = 0; in_ir = 0; in_pc = 0; out_ready = 0;
    repeat (3) @(negedge clk);
    #4 rst_n = 1;

    // Reset then single R-type add.
    cyc(1, 32'h00000820, 1, 0);
    repeat (2) cyc(0, 0, 1, 0);

    // Reference sequence back-to-back.
    cyc(1, 32'h2002000a, 1, 0);
    cyc(1, 32'h2403000a, 1, 0);
    cyc(1, 32'h00432021, 1, 0);
    cyc(1, 32'h00442824, 1, 0);
    cyc(1, 32'h00023080, 1, 0);
    repeat (2) cyc(0, 0, 1, 0);

    // Back-pressure to full, single pop, refill across the wrap.
    for (int i = 0; i < 6; i++) cyc(1, 32'h00000820 | (i << 11), 0, 0);
    cyc(0, 0, 1, 0);
    cyc(1, 32'h20070007, 0, 0);
    cyc(0, 0, 0, 0);
    repeat (7) cyc(0, 0, 1, 0);

    // Immediate extension and an illegal opcode.
    cyc(1, 32'h2001ffff, 1, 0);
    cyc(1, 32'h3001ffff, 1, 0);
    cyc(1, 32'hfc000000, 1, 0);
    repeat (2) cyc(0, 0, 1, 0);

    // Flush with a full output stage and three queued entries.
    for (int i = 0; i < 4; i++) cyc(1, 32'h34000000 | i, 0, 0);
    cyc(1, 32'h35550001, 0, 1);
    cyc(1, 32'h00221820, 1, 0);
    repeat (2) cyc(0, 0, 1, 0);

    // Asynchronous reset between edges with the queue partly full.
    for (int i = 0; i < 3; i++) cyc(1, 32'h21080001, 0, 0);
    @(negedge clk);
    #5 rst_n = 0;
    sb.delete();
    #1;
    check("async_out_valid", 128'(out_valid), 128'(0));
    check("async_count", 128'(count), 128'(0));
    check("async_in_ready", 128'(in_ready), 128'(0));
    in_valid = 0;
    repeat (2) @(negedge clk);
    #4 rst_n = 1;
    cyc(1, 32'h3c0bffff, 1, 0);
    repeat (2) cyc(0, 0, 1, 0);

    // Randomized traffic with back-pressure and occasional flush.
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 3) != 0), rand_ir(), ($urandom_range(0, 9) < 6),
          ($urandom_range(0, 49) == 0));

    repeat (8) cyc(0, 0, 1, 0);
    @(negedge clk);
    #4;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ir_queue_decode.md
Name: ir_queue_decode

Overview:
- Parametrised successor to the combinational instruction-register decoder.
- Buffers fetched MIPS instructions, with their PCs, in a DEPTH-entry queue.
- Decodes the queue head into a registered output stage with a valid/ready handshake.
- Sits between instruction fetch and the register-read/execute stage; supports back-pressure, pipeline flush and illegal-opcode flagging.

Parameters:
- DATA_W, 32, width of the extended immediate; must be ≥ 16.
- PC_W, 32, width of the PC tag carried alongside each instruction.
- DEPTH, 4, queue entries, excluding the output register; power of two, ≥ 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; discards all queued and output-stage instructions.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  block can accept an instruction this cycle.
- in_ir  in  32  instruction word.
- in_pc  in  PC_W  PC of in_ir.
- out_valid  out  1  decoded instruction present.
- out_ready  in  1  consumer takes the output this cycle.
- out_pc  out  PC_W  PC of the decoded instruction.
- out_op  out  6  ir[31:26].
- out_rs  out  5  ir[25:21].
- out_rt  out  5  ir[20:16].
- out_rd  out  5  ir[15:11].
- out_shamt  out  5  ir[10:6].
- out_funct  out  6  ir[5:0].
- out_imm  out  DATA_W  extended ir[15:0].
- out_is_rtype  out  1  legal R-type instruction.
- out_is_imm  out  1  legal I-type ALU instruction.
- out_illegal  out  1  instruction not in the supported set.
- count  out  clog2(DEPTH)+1  occupied queue entries, excluding the output register.

Behaviour:
- **Reset (rst_n=0, asynchronous):**
  - out_valid=0, count=0, in_ready=0 while asserted.
  - All out_* fields = 0; queue pointers = 0.
  - in_ready rises in the first cycle after rst_n deasserts.
- **Handshakes:**
  - Accept when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - in_ready = (count < DEPTH) && !flush; combinational, with no dependence on in_valid.
- **Output register load:** the output register loads when it is empty, or being popped, in the same cycle.
  - Source = queue head if count>0.
  - Otherwise the bypass path: the accepted input loads the output register directly. Latency is 1 cycle from accept to out_valid.
- **Ordering:** strict FIFO; instruction order is never changed.
- **Simultaneous events:**
  - Accept with a head move: count unchanged.
  - Accept while the output register is full and not popped: count+1.
  - A pop with count=0 and no accept: out_valid=0 next cycle.
  - A full queue with a pop in the same cycle still holds in_ready=0; there is no combinational ready-through.
- **flush:** highest priority over every other event.
  - Next cycle: out_valid=0, count=0, pointers reset.
  - The input is not accepted in the flush cycle.
  - out_* data fields may hold stale values while out_valid=0.
- **Decode rules (registered with the output stage):**
  - R-type: op=0x00 with funct ∈ {0x20 add, 0x21 addu, 0x24 and, 0x25 or, 0x00 sll}, giving out_is_rtype=1.
  - I-type: op ∈ {0x08 addi, 0x09 addiu, 0x0C andi, 0x0D ori}, giving out_is_imm=1.
  - Immediate extension: sign-extend to DATA_W for addi/addiu; zero-extend for andi/ori. For all other instructions out_imm = sign-extended ir[15:0].
  - Anything else: out_illegal=1, is_rtype=0, is_imm=0. Field outputs are still populated from ir.
  - is_rtype, is_imm and illegal are mutually exclusive; exactly one is 1 when out_valid=1.
- **Wrap-around:** pointers wrap modulo DEPTH. The full condition comes from count, not from pointer equality.

Test Plan:
- **Reset, then single instruction:**
  - Stimulus: reset; push 0x00000820, pc=0x0, out_ready=1.
  - Required: out_valid exactly one cycle after accept; rd=1, funct=0x20, is_rtype=1, count stays 0.
- **Reference sequence:**
  - Stimulus: push 0x2002000a, 0x2403000a, 0x00432021, 0x00442824, 0x00023080 back-to-back with out_ready=1.
  - Required:
    - addi: rt=2, imm=0x0000000a, is_imm=1.
    - addiu: rt=3, is_imm=1.
    - addu: rd=4, funct=0x21.
    - and: rd=5, funct=0x24.
    - sll: rd=6, rt=2, shamt=2, funct=0x00.
    - All in order, one per cycle.
- **Back-pressure and full:**
  - Stimulus: out_ready=0; push 6 instructions.
  - Required: DEPTH+1=5 accepted; count=4, in_ready=0.
  - Then: raise out_ready for one cycle. Required: one pop, and the next instruction enters the queue the following cycle. FIFO order holds across pointer wrap.
- **Immediate extension:**
  - Stimulus: push 0x2001ffff (addi) and 0x3001ffff (andi).
  - Required: imm=0xffffffff for addi, 0x0000ffff for andi. Also out_illegal=1 for 0xfc000000.
- **Flush mid-stream:**
  - Stimulus: 3 queued instructions plus a valid output; flush=1 with in_valid=1 in the same cycle.
  - Required: next cycle out_valid=0, count=0, and the flush-cycle input is not accepted.
  - Then: a subsequent push appears 1 cycle after accept.
- **Async reset mid-operation:**
  - Stimulus: assert rst_n low between clock edges with the queue partly full.
  - Required: out_valid and count drop to 0 immediately without a clock edge.
